// File: rtl/dmem_pkg.sv
// Shared encodings for the banked data memory: access size codes, default lane count
// and the size-to-byte-count helper used on both the request and response paths.
package dmem_pkg;

   localparam int LANES_DEF = 4;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   // Bytes touched by an access; sizes wider than the bank collapse to a full word.
   function automatic logic [3:0] size_nbytes(input logic [1:0] size, input logic [3:0] lanes);
      logic [3:0] nb;
      case (size_e'(size))
         SIZE_B:  nb = 4'd1;
         SIZE_H:  nb = 4'd2;
         SIZE_W:  nb = 4'd4;
         default: nb = 4'd8;
      endcase
      return (nb > lanes) ? lanes : nb;
   endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Load-response FIFO: registered storage, head presented combinationally from the
// storage array, simultaneous push and pop allowed when full.
module dmem_rsp_fifo
   import dmem_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      pop_ok_s  = pop && (cnt_q != {CW{1'b0}});
      push_ok_s = push && ((cnt_q != CW'(DEPTH)) || pop_ok_s);
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? {PW{1'b0}} : wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? {PW{1'b0}} : rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Data storage; contents are meaningless once pointers reset, so it is not cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/dmem_banked.sv
// Byte-banked data memory front end: steers misaligned loads/stores across LANES
// byte-wide SRAM macros and realigns, masks and extends load data into an ordered FIFO.
module dmem_banked
   import dmem_pkg::*;
#(
   parameter int LANES     = LANES_DEF,
   parameter int BANK_AW   = 9,
   parameter int SRAM_LAT  = 1,
   parameter int RSP_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_we,
   input  logic [31:0]                     req_addr,
   input  logic [1:0]                      req_size,
   input  logic                            req_unsigned,
   input  logic [8*LANES-1:0]              req_wdata,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [8*LANES-1:0]              rsp_data,
   output logic [LANES-1:0]                CEN,
   output logic [LANES-1:0]                GWEN,
   output logic [LANES-1:0][7:0]           WEN,
   output logic [LANES-1:0][BANK_AW-1:0]   A,
   output logic [LANES-1:0][7:0]           D,
   input  logic [LANES-1:0][7:0]           Q
);

   localparam int OFFW = $clog2(LANES);
   localparam int DW   = 8*LANES;
   localparam int CW   = $clog2(RSP_DEPTH+1);
   localparam int OW   = CW + 1;
   localparam int LO   = SRAM_LAT - 1;

   logic [OFFW-1:0]              req_off_s;
   logic [BANK_AW-1:0]           row_s, row_inc_s;
   logic [3:0]                   req_nb_s;
   logic [LANES-1:0][OFFW-1:0]   lane_idx_s;
   logic [LANES-1:0]             lane_en_s;
   logic [LANES-1:0][7:0]        wbytes_s;
   logic [OW-1:0]                inflight_s, occ_s;
   logic [CW-1:0]                fifo_cnt_s;
   logic                         acc_s, pop_s, load_ok_s;

   logic [SRAM_LAT-1:0]              pv_q, pv_d;
   logic [SRAM_LAT-1:0][OFFW-1:0]    poff_q, poff_d;
   logic [SRAM_LAT-1:0][1:0]         psize_q, psize_d;
   logic [SRAM_LAT-1:0]              puns_q, puns_d;

   logic [LANES-1:0][7:0]        rot_s, rsp_bytes_s;
   logic [3:0]                   rnb_s;
   logic                         sign_s;
   logic [7:0]                   fill_s;

   // Request decode, flow control and macro strobes for the acceptance cycle.
   always_comb begin
      req_off_s = req_addr[OFFW-1:0];
      row_s     = req_addr[OFFW +: BANK_AW];
      row_inc_s = row_s + 1'b1;
      req_nb_s  = size_nbytes(req_size, 4'(LANES));
      wbytes_s  = req_wdata;

      inflight_s = {OW{1'b0}};
      for (int k = 0; k < SRAM_LAT; k++) begin
         inflight_s = inflight_s + OW'(pv_q[k]);
      end
      // A pop this cycle frees a slot in time for a load accepted now.
      occ_s     = inflight_s + OW'(fifo_cnt_s) - OW'(pop_s);
      load_ok_s = occ_s < OW'(RSP_DEPTH);
      req_ready = !rst && (req_we || load_ok_s);
      acc_s     = req_valid && req_ready;

      for (int i = 0; i < LANES; i++) begin
         lane_idx_s[i] = OFFW'(i) - req_off_s;
         lane_en_s[i]  = int'(lane_idx_s[i]) < int'(req_nb_s);
         A[i]    = (OFFW'(i) < req_off_s) ? row_inc_s : row_s;
         D[i]    = wbytes_s[lane_idx_s[i]];
         CEN[i]  = !(acc_s && lane_en_s[i]);
         GWEN[i] = acc_s ? !req_we : 1'b1;
         WEN[i]  = (acc_s && lane_en_s[i]) ? 8'h00 : 8'hFF;
      end
   end

   // Load sideband pipeline that tracks the macro read latency.
   always_comb begin
      pv_d[0]    = acc_s && !req_we;
      poff_d[0]  = req_off_s;
      psize_d[0] = req_size;
      puns_d[0]  = req_unsigned;
      for (int k = 1; k < SRAM_LAT; k++) begin
         pv_d[k]    = pv_q[k-1];
         poff_d[k]  = poff_q[k-1];
         psize_d[k] = psize_q[k-1];
         puns_d[k]  = puns_q[k-1];
      end
   end

   // Sideband pipeline registers; reset drops loads in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q    <= {SRAM_LAT{1'b0}};
         poff_q  <= '0;
         psize_q <= '0;
         puns_q  <= {SRAM_LAT{1'b0}};
      end else begin
         pv_q    <= pv_d;
         poff_q  <= poff_d;
         psize_q <= psize_d;
         puns_q  <= puns_d;
      end
   end

   // Realign macro bytes to request order, then mask and extend.
   always_comb begin
      rnb_s  = size_nbytes(psize_q[LO], 4'(LANES));
      sign_s = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         rot_s[j] = Q[OFFW'(j) + poff_q[LO]];
         sign_s   = (j == int'(rnb_s) - 1) ? rot_s[j][7] : sign_s;
      end
      fill_s = puns_q[LO] ? 8'h00 : {8{sign_s}};
      for (int j = 0; j < LANES; j++) begin
         rsp_bytes_s[j] = (j < int'(rnb_s)) ? rot_s[j] : fill_s;
      end
   end

   assign rsp_valid = !rst && (fifo_cnt_s != {CW{1'b0}});
   assign pop_s     = rsp_valid && rsp_ready;

   dmem_rsp_fifo #(
      .WIDTH (DW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pv_q[LO]),
      .wdata (rsp_bytes_s),
      .pop   (pop_s),
      .rdata (rsp_data),
      .count (fifo_cnt_s)
   );

   generate
      if (OFFW + BANK_AW < 32) begin : g_unused_addr
         logic unused_addr_s;
         assign unused_addr_s = ^req_addr[31:OFFW+BANK_AW];
      end
   endgenerate

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked with behavioural byte macros; expected load data is
// queued at acceptance and compared by an independent response monitor.
module tb_dmem_banked;
   import dmem_pkg::*;

   localparam int LANES   = 4;
   localparam int BANK_AW = 9;

   logic clk = 1'b0;
   logic rst;
   logic req_valid, req_ready, req_we, req_unsigned;
   logic [31:0] req_addr, req_wdata, rsp_data;
   logic [1:0]  req_size;
   logic rsp_valid, rsp_ready;
   logic [LANES-1:0] CEN, GWEN;
   logic [LANES-1:0][7:0] WEN, D, Q;
   logic [LANES-1:0][BANK_AW-1:0] A;

   dmem_banked dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .CEN(CEN), .GWEN(GWEN),
      .WEN(WEN), .A(A), .D(D), .Q(Q)
   );

   always #5 clk = ~clk;

   // Behavioural macros: one-cycle registered read, bit-masked write.
   logic [7:0] mem [LANES][2**BANK_AW];
   logic [7:0] q_r [LANES];
   always @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (!CEN[l]) begin
            if (!GWEN[l]) mem[l][A[l]] <= (mem[l][A[l]] & WEN[l]) | (D[l] & ~WEN[l]);
            else          q_r[l] <= mem[l][A[l]];
         end
      end
   end
   always_comb for (int l = 0; l < LANES; l++) Q[l] = q_r[l];

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [LANES-1:0][BANK_AW-1:0] snap_a;
   logic [LANES-1:0] snap_cen, snap_gwen;
   logic [LANES-1:0][7:0] snap_wen;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %h expected none", rsp_data);
         end else begin
            check_eq("rsp_data", rsp_data, exp_q.pop_front());
         end
      end
   end

   // Drive one request until accepted; returns just after the accepting edge.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input logic [31:0] exp,
                        input bit expect_rsp, output int waits);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd; waits = 0;
      while (1) begin
         @(negedge clk);
         if (req_ready) break;
         waits++;
         if (waits > 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no req_ready expected accept for addr %h", addr);
            req_valid = 1'b0;
            return;
         end
      end
      snap_a = A; snap_cen = CEN; snap_gwen = GWEN; snap_wen = WEN;
      if (!we && expect_rsp) exp_q.push_back(exp);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [31:0] bp_addr [4] = '{32'h100, 32'h103, 32'h101, 32'h102};
   logic [31:0] bp_exp  [4] = '{32'h12345678, 32'hAABBCC12, 32'hCC123456, 32'hBBCC1234};

   initial begin
      int w;
      int idx;
      bit acc;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
      req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'h0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check_eq("rst_cen", 32'(CEN), 32'hF);
      check_eq("rst_gwen", 32'(GWEN), 32'hF);
      check_eq("rst_wen", 32'(WEN), 32'hFFFFFFFF);
      @(posedge clk); #1;
      rst = 1'b0;

      // Aligned word store/load with latency check.
      issue(1'b1, 32'h100, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0, w);
      check_eq("store_accept_wait", 32'(w), 32'h0);
      issue(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b1, w);
      @(negedge clk);
      check_eq("lat_cycle1_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      check_eq("lat_cycle2_valid", 32'(rsp_valid), 32'h1);
      @(posedge clk); #1;

      // Misaligned word crossing a row boundary.
      issue(1'b1, 32'h103, 2'd2, 1'b0, 32'hAABBCCDD, 32'h0, 1'b0, w);
      check_eq("mis_a_lane0", 32'(snap_a[0]), 32'h41);
      check_eq("mis_a_lane1", 32'(snap_a[1]), 32'h41);
      check_eq("mis_a_lane2", 32'(snap_a[2]), 32'h41);
      check_eq("mis_a_lane3", 32'(snap_a[3]), 32'h40);
      check_eq("mis_cen", 32'(snap_cen), 32'h0);
      check_eq("mis_gwen", 32'(snap_gwen), 32'h0);
      check_eq("mis_mem_l3", 32'(mem[3][9'h40]), 32'hDD);
      check_eq("mis_mem_l0", 32'(mem[0][9'h41]), 32'hCC);
      issue(1'b0, 32'h103, 2'd2, 1'b0, 32'h0, 32'hAABBCCDD, 1'b1, w);

      // Byte store and sign/zero extension.
      issue(1'b1, 32'h100, 2'd0, 1'b0, 32'h00000080, 32'h0, 1'b0, w);
      check_eq("byte_cen", 32'(snap_cen), 32'hE);
      check_eq("byte_wen", 32'(snap_wen), 32'hFFFFFF00);
      issue(1'b0, 32'h100, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b1, w);
      issue(1'b0, 32'h100, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b1, w);
      issue(1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 32'hFFFFDD22, 1'b1, w);
      issue(1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 32'h0000DD22, 1'b1, w);

      // Store right behind a load must not disturb it; then back-to-back loads.
      issue(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDD223380, 1'b1, w);
      issue(1'b1, 32'h100, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0, w);
      issue(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b1, w);
      check_eq("tput_wait0", 32'(w), 32'h0);
      issue(1'b0, 32'h103, 2'd2, 1'b0, 32'h0, 32'hAABBCC12, 1'b1, w);
      check_eq("tput_wait1", 32'(w), 32'h0);
      issue(1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 32'hCC123456, 1'b1, w);
      check_eq("tput_wait2", 32'(w), 32'h0);
      issue(1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 32'h00001234, 1'b1, w);
      check_eq("tput_wait3", 32'(w), 32'h0);
      wait_drain();

      // Backpressure: only RSP_DEPTH loads fit while rsp_ready is low.
      rsp_ready = 1'b0;
      idx = 0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = bp_addr[0];
      repeat (8) begin
         @(negedge clk);
         acc = req_valid && req_ready;
         if (acc) begin
            exp_q.push_back(bp_exp[idx]);
            idx++;
         end
         @(posedge clk); #1;
         if (idx < 4) req_addr = bp_addr[idx];
         else req_valid = 1'b0;
      end
      check_eq("bp_accepted", 32'(idx), 32'h2);
      @(negedge clk);
      check_eq("bp_req_ready", 32'(req_ready), 32'h0);
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_hold_data", rsp_data, 32'h12345678);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_drain();
      issue(1'b0, bp_addr[2], 2'd2, 1'b0, 32'h0, bp_exp[2], 1'b1, w);
      issue(1'b0, bp_addr[3], 2'd2, 1'b0, 32'h0, bp_exp[3], 1'b1, w);
      wait_drain();

      // Reset right after a load is accepted drops it.
      issue(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, w);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
         check_eq("mid_rst_req_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      issue(1'b0, 32'h103, 2'd2, 1'b0, 32'h0, 32'hAABBCC12, 1'b1, w);
      check_eq("post_rst_wait", 32'(w), 32'h0);
      wait_drain();

      // Half store at the last byte of the last row wraps lane 0 to row 0.
      issue(1'b1, 32'h7FF, 2'd1, 1'b0, 32'h0000BEEF, 32'h0, 1'b0, w);
      check_eq("wrap_a_lane0", 32'(snap_a[0]), 32'h0);
      check_eq("wrap_a_lane3", 32'(snap_a[3]), 32'h1FF);
      check_eq("wrap_cen", 32'(snap_cen), 32'h6);
      check_eq("wrap_mem_l0", 32'(mem[0][9'h0]), 32'hBE);
      check_eq("wrap_mem_l3", 32'(mem[3][9'h1FF]), 32'hEF);
      issue(1'b0, 32'h7FF, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b1, w);
      issue(1'b0, 32'h7FF, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b1, w);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_banked.md
DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning the number of byte-wide SRAM macros (power of two, 2..8).
REQ-002 The block SHALL have parameter BANK_AW, default 9, meaning the row address width of each macro.
REQ-003 The block SHALL have parameter SRAM_LAT, default 1, meaning the macro read latency in cycles (1 or 2).
REQ-004 The block SHALL have parameter RSP_DEPTH, default 2, meaning the response FIFO entries (>= SRAM_LAT+1).
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_we  in  1  1=store, 0=load.
- req_addr  in  32  byte address; misaligned allowed.
- req_size  in  2  0=byte, 1=half, 2=word (LANES bytes).
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- req_wdata  in  8*LANES  store data, LSB-aligned.
- rsp_valid  out  1  load data available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8*LANES  extended load data.
- CEN  out  LANES x 1  macro chip enable, active-low.
- GWEN  out  LANES x 1  macro global write enable, active-low.
- WEN  out  LANES x 8  macro bit write enable, active-low.
- A  out  LANES x BANK_AW  macro row address.
- D  out  LANES x 8  macro write byte.
- Q  in  LANES x 8  macro read byte.

Function
REQ-006 The block SHALL let off = addr mod LANES and row = addr / LANES; lane i SHALL use row+1 when i < off, else row, truncated to BANK_AW bits (top row wraps to row 0).
REQ-007 The block SHALL give lane i the request byte index (i - off) mod LANES, for D and the write mask alike.
REQ-008 The block SHALL set byte mask = (1 << 2^size) - 1; a size with 2^size > LANES SHALL be treated as full word.
REQ-009 The block SHALL, in the acceptance cycle, drive CEN=0 only on masked lanes (loads: masked lanes only), GWEN=!req_we, WEN=all-zero on masked lanes; all other cycles CEN=1, GWEN=1, WEN=all-ones.
REQ-010 The block SHALL drive req_ready=1 for stores whenever not in reset; stores are posted and produce no response.
REQ-011 The block SHALL drive req_ready=1 for loads only when (loads in flight + FIFO count) < RSP_DEPTH.
REQ-012 The block SHALL carry off, size and unsigned through a SRAM_LAT-deep in-flight pipeline alongside each accepted load.
REQ-013 The block SHALL, SRAM_LAT cycles after acceptance, rotate Q back by off, then mask to 2^size bytes and extend, then push the result into the FIFO.
REQ-014 The block SHALL present the FIFO head on rsp_valid/rsp_data, so the first rsp_valid occurs SRAM_LAT+1 cycles after acceptance.
REQ-015 The block SHALL hold rsp_data stable while rsp_valid && !rsp_ready.
REQ-016 The block SHALL allow simultaneous push and pop on a full FIFO, with count unchanged and order preserved.
REQ-017 The block SHALL keep responses in strict acceptance order; a store accepted after a load SHALL NOT alter that load's returned data.
REQ-018 The block SHALL give back-to-back loads full throughput (one per cycle) while rsp_ready=1.

Reset
REQ-019 The block SHALL, while rst=1, drive req_ready=0, rsp_valid=0, CEN=1, GWEN=1 and WEN=all-ones.
REQ-020 The block SHALL, on rst=1, clear the in-flight pipeline and FIFO, dropping loads in flight mid-operation; macro contents are unaffected.
REQ-021 The block SHALL resume accepting requests in the first cycle after rst deasserts.

Structure
REQ-022 The block SHALL take the size encoding (SIZE_B/SIZE_H/SIZE_W) and LANES default from package dmem_pkg.
REQ-023 The block SHALL implement the response FIFO as sub-module dmem_rsp_fifo (parameters WIDTH, DEPTH; count output).

Verification
REQ-024 The bench SHALL store word 0x11223344 to 0x100, load word 0x100 -> rsp_data=0x11223344 two cycles after acceptance (SRAM_LAT=1).
REQ-025 The bench SHALL store word 0xAABBCCDD to 0x103, then load word 0x103 -> 0xAABBCCDD, and confirm lanes 0-2 addressed row 0x41, lane 3 row 0x40.
REQ-026 The bench SHALL load byte 0x100 after storing 0x80 there, signed -> 0xFFFFFF80, unsigned -> 0x00000080.
REQ-027 The bench SHALL hold rsp_ready=0 and issue 4 loads -> only RSP_DEPTH accepted, req_ready=0 after, all data stable; releasing rsp_ready drains in order.
REQ-028 The bench SHALL assert rst one cycle after a load is accepted -> no rsp_valid ever appears for it; the next load returns correct data.
REQ-029 The bench SHALL store half 0xBEEF to the last byte of row 2^BANK_AW-1 -> the upper byte lands in row 0 of lane 0.
